conveyor_unit: RTL and testbench
================================

CONVEYOR_UNIT -- requirements
Module: conveyor_unit

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, data word width.
REQ-002 SHALL have parameter CONVEYOR_ADDR_WIDTH, default 4, log2 of slot count; CONVEYOR_SIZE = 2^CONVEYOR_ADDR_WIDTH.
REQ-003 SHALL have parameter RETURN_CHANNELS, default 2, number of independent result write-back channels (1..8).
REQ-004 SHALL have localparam FAULT_ADDR_WIDTH = 3; slot = {finished, fault[2:0], word}.
REQ-005 SHALL use clk as its single clock; all state updates on the rising edge of clk.
REQ-006 SHALL use reset as its reset: synchronous, active-high, sampled on the rising edge of clk.
REQ-007 SHALL have instruction, input, 8 bits; decoded opcode; bits [3:0] give the CVZ offset.
REQ-008 SHALL have instr_valid, input, 1 bit; instruction is being issued this cycle.
REQ-009 SHALL have dispatch, input, 1 bit; issued op launches an async result needing a slot.
REQ-010 SHALL have servicing_interrupt, input, 1 bit; interrupt entry this cycle.
REQ-011 SHALL have interrupt_value, input, WORD_WIDTH; value pushed on interrupt entry.
REQ-012 SHALL have ret_valid, ret_tag, ret_value, ret_fault: inputs, RETURN_CHANNELS x {1, CONVEYOR_ADDR_WIDTH, WORD_WIDTH, 3} bits; result write-back per channel.
REQ-013 SHALL have dispatch_tag, output, CONVEYOR_ADDR_WIDTH; slot allocated to the current dispatch.
REQ-014 SHALL have conveyor_value, output, WORD_WIDTH; word of the slot at head + instruction[3:0].
REQ-015 SHALL have halt, output, 1 bit; and fault, output, 3 bits; core stall and fault code.

Function
REQ-016 SHALL hold CONVEYOR_SIZE slots and a head pointer in registers; conveyor_value, halt, fault and dispatch_tag SHALL be combinational from registered state and current inputs.
REQ-017 SHALL compute access index = head + instruction[3:0], modulo CONVEYOR_SIZE (wrap-around).
REQ-018 On instr_valid with instruction matching I_CVZ: halt = !finished(access); fault = finished ? slot fault : F_NONE (0); head unchanged.
REQ-019 On instr_valid, dispatch, not halted: next head = head - 1; slot (head - 1) SHALL be written {finished=0, fault=0, word=0}; dispatch_tag = head - 1.
REQ-020 On servicing_interrupt: takes priority over instruction; next head = head - 1; slot (head - 1) written {1, F_NONE, interrupt_value}; halt = 0; fault = F_NONE.
REQ-021 Each cycle, for each channel c with ret_valid[c] and slot ret_tag[c] not finished: slot written {1, ret_fault[c], ret_value[c]} at next edge.
REQ-022 ret_valid to a slot already finished SHALL be ignored (no state change).
REQ-023 Two channels targeting the same tag in one cycle: lowest channel index wins; others ignored.
REQ-024 Return and dispatch/interrupt to the same slot in one cycle: dispatch/interrupt write wins.
REQ-025 Return and CVZ to the same slot in one cycle: CVZ sees pre-edge state (halt=1); next cycle CVZ completes.
REQ-026 When no instruction is valid and no interrupt, halt = 0, fault = F_NONE, head unchanged.

Reset
REQ-027 On reset, head SHALL be 0 and every slot {finished=1, fault=F_NONE, word=0}.
REQ-028 Reset SHALL override all same-cycle dispatch, return and interrupt activity; outputs after reset: halt=0, fault=0, dispatch_tag=CONVEYOR_SIZE-1.

Configuration
REQ-029 Macro CONVEYOR_PENDING_LIMIT_EN: when defined, an outstanding-slot counter (0..CONVEYOR_SIZE) SHALL track unfinished slots; dispatch with count = CONVEYOR_SIZE SHALL assert halt and not allocate; counter +1 per accepted dispatch, -1 per accepted return, net in the same cycle.
REQ-030 Without CONVEYOR_PENDING_LIMIT_EN: no counter; dispatch always allocates, overwriting the oldest slot even if pending.

Verification
REQ-031 Reset, then CVZ offset 3 -> halt=0, fault=0, conveyor_value=0.
REQ-032 Dispatch at head 0 -> dispatch_tag=15; next cycle CVZ offset 0 -> halt=1; ret_valid[0], tag 15, value 0xDEADBEEF, fault 0 -> following cycle CVZ offset 0 -> halt=0, value 0xDEADBEEF.
REQ-033 Channels 0 and 1 both return tag 15 (0x11, 0x22) same cycle -> slot 15 holds 0x11.
REQ-034 Return tag 15 with ret_fault=2 -> CVZ offset 0 -> fault=2, halt=0.
REQ-035 Interrupt with interrupt_value 0x5A at head 0 -> head 15, CVZ offset 0 -> value 0x5A, halt=0.
REQ-036 With CONVEYOR_PENDING_LIMIT_EN, 16 dispatches without returns -> 17th dispatch halt=1, head unchanged; one return -> next dispatch accepted.

Source files
------------

// File: rtl/conveyor_unit.sv
// Result conveyor: a ring of slots indexed relative to a head pointer; async results land by tag.
// Optional CONVEYOR_PENDING_LIMIT_EN adds an outstanding-slot counter that stalls dispatch when full.
module conveyor_unit #(
  parameter int WORD_WIDTH          = 32,
  parameter int CONVEYOR_ADDR_WIDTH = 4,
  parameter int RETURN_CHANNELS     = 2,
  localparam int FAULT_ADDR_WIDTH   = 3
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic [7:0]                                           instruction,
  input  logic                                                 instr_valid,
  input  logic                                                 dispatch,
  input  logic                                                 servicing_interrupt,
  input  logic [WORD_WIDTH-1:0]                                interrupt_value,
  input  logic [RETURN_CHANNELS-1:0]                           ret_valid,
  input  logic [RETURN_CHANNELS-1:0][CONVEYOR_ADDR_WIDTH-1:0]  ret_tag,
  input  logic [RETURN_CHANNELS-1:0][WORD_WIDTH-1:0]           ret_value,
  input  logic [RETURN_CHANNELS-1:0][FAULT_ADDR_WIDTH-1:0]     ret_fault,
  output logic [CONVEYOR_ADDR_WIDTH-1:0]                       dispatch_tag,
  output logic [WORD_WIDTH-1:0]                                conveyor_value,
  output logic                                                 halt,
  output logic [FAULT_ADDR_WIDTH-1:0]                          fault
);

  localparam int CONVEYOR_SIZE = 2 ** CONVEYOR_ADDR_WIDTH;
  localparam logic [3:0] I_CVZ = 4'h1;
  localparam logic [FAULT_ADDR_WIDTH-1:0] F_NONE = '0;

  typedef logic [CONVEYOR_ADDR_WIDTH-1:0] addr_t;
  localparam addr_t ONE_SLOT = addr_t'(1);

  logic [CONVEYOR_SIZE-1:0]                       slot_finished;
  logic [CONVEYOR_SIZE-1:0][FAULT_ADDR_WIDTH-1:0] slot_fault;
  logic [CONVEYOR_SIZE-1:0][WORD_WIDTH-1:0]       slot_word;
  addr_t                                          head;

  addr_t                          alloc_slot;
  addr_t                          access_idx;
  logic [CONVEYOR_ADDR_WIDTH+3:0] access_sum;
  logic                           is_cvz;
  logic                           dispatch_accept;
  logic                           alloc_en;
  logic [RETURN_CHANNELS-1:0]     ret_apply;

  // Offset is added at full width, then truncated so the index wraps around the ring.
  assign access_sum = {4'b0000, head} + {{CONVEYOR_ADDR_WIDTH{1'b0}}, instruction[3:0]};
  assign access_idx = access_sum[CONVEYOR_ADDR_WIDTH-1:0];
  assign alloc_slot = head - ONE_SLOT;
  assign is_cvz     = instr_valid && (instruction[7:4] == I_CVZ);

  assign dispatch_tag   = alloc_slot;
  assign conveyor_value = slot_word[access_idx];

`ifdef CONVEYOR_PENDING_LIMIT_EN
  localparam logic [CONVEYOR_ADDR_WIDTH:0] FULL_COUNT = (CONVEYOR_ADDR_WIDTH+1)'(CONVEYOR_SIZE);
  localparam logic [CONVEYOR_ADDR_WIDTH:0] ONE_COUNT  = (CONVEYOR_ADDR_WIDTH+1)'(1);

  logic [CONVEYOR_ADDR_WIDTH:0] pending_count;
  logic [CONVEYOR_ADDR_WIDTH:0] pending_next;
  logic                         pending_full;

  assign pending_full = (pending_count == FULL_COUNT);
`endif

  always_comb begin
    halt  = 1'b0;
    fault = F_NONE;
    if (!servicing_interrupt) begin
      if (is_cvz) begin
        halt = !slot_finished[access_idx];
        if (slot_finished[access_idx]) begin
          fault = slot_fault[access_idx];
        end
      end
`ifdef CONVEYOR_PENDING_LIMIT_EN
      if (instr_valid && dispatch && pending_full) begin
        halt = 1'b1;
      end
`endif
    end
  end

  assign dispatch_accept = !servicing_interrupt && instr_valid && dispatch && !halt;
  assign alloc_en        = servicing_interrupt || dispatch_accept;

  // A return is dropped if its slot is already finished, is being reallocated this
  // cycle, or a lower-numbered channel targets the same tag.
  always_comb begin
    ret_apply = '0;
    for (int c = 0; c < RETURN_CHANNELS; c++) begin
      ret_apply[c] = ret_valid[c] && !slot_finished[ret_tag[c]] &&
                     !(alloc_en && (ret_tag[c] == alloc_slot));
      for (int d = 0; d < c; d++) begin
        if (ret_valid[d] && (ret_tag[d] == ret_tag[c])) begin
          ret_apply[c] = 1'b0;
        end
      end
    end
  end

`ifdef CONVEYOR_PENDING_LIMIT_EN
  // Counter equals the number of unfinished slots; overwriting a pending slot retires it.
  always_comb begin
    pending_next = pending_count;
    if (dispatch_accept) begin
      pending_next = pending_next + ONE_COUNT;
    end
    if (alloc_en && !slot_finished[alloc_slot]) begin
      pending_next = pending_next - ONE_COUNT;
    end
    for (int c = 0; c < RETURN_CHANNELS; c++) begin
      if (ret_apply[c]) begin
        pending_next = pending_next - ONE_COUNT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_count <= '0;
    end else begin
      pending_count <= pending_next;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      head          <= '0;
      slot_finished <= '1;
      slot_fault    <= '0;
      slot_word     <= '0;
    end else begin
      for (int c = 0; c < RETURN_CHANNELS; c++) begin
        if (ret_apply[c]) begin
          slot_finished[ret_tag[c]] <= 1'b1;
          slot_fault[ret_tag[c]]    <= ret_fault[c];
          slot_word[ret_tag[c]]     <= ret_value[c];
        end
      end
      if (alloc_en) begin
        head                      <= alloc_slot;
        slot_finished[alloc_slot] <= servicing_interrupt;
        slot_fault[alloc_slot]    <= F_NONE;
        slot_word[alloc_slot]     <= servicing_interrupt ? interrupt_value : '0;
      end
    end
  end

endmodule

// File: tb/tb_conveyor_unit.sv
// Directed, table-driven bench for conveyor_unit (default parameters).
module tb_conveyor_unit;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       instruction;
  logic             instr_valid;
  logic             dispatch;
  logic             servicing_interrupt;
  logic [31:0]      interrupt_value;
  logic [1:0]       ret_valid;
  logic [1:0][3:0]  ret_tag;
  logic [1:0][31:0] ret_value;
  logic [1:0][2:0]  ret_fault;
  logic [3:0]       dispatch_tag;
  logic [31:0]      conveyor_value;
  logic             halt;
  logic [2:0]       fault;

  always #5 clk = ~clk;

  conveyor_unit dut (
    .clk                 (clk),
    .reset               (reset),
    .instruction         (instruction),
    .instr_valid         (instr_valid),
    .dispatch            (dispatch),
    .servicing_interrupt (servicing_interrupt),
    .interrupt_value     (interrupt_value),
    .ret_valid           (ret_valid),
    .ret_tag             (ret_tag),
    .ret_value           (ret_value),
    .ret_fault           (ret_fault),
    .dispatch_tag        (dispatch_tag),
    .conveyor_value      (conveyor_value),
    .halt                (halt),
    .fault               (fault)
  );

  typedef struct {
    bit               rst;
    bit               iv;
    logic [7:0]       instr;
    bit               disp;
    bit               irq;
    logic [31:0]      ival;
    logic [1:0]       rv;
    logic [1:0][3:0]  rt;
    logic [1:0][31:0] rval;
    logic [1:0][2:0]  rf;
    bit               chk;
    bit               e_halt;
    logic [2:0]       e_fault;
    logic [31:0]      e_val;
    logic [3:0]       e_tag;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t op(bit iv, logic [7:0] instr, bit disp, bit irq, logic [31:0] ival,
                              bit eh, logic [2:0] ef, logic [31:0] ev, logic [3:0] et);
    vec_t v;
    v.rst = 1'b0; v.iv = iv; v.instr = instr; v.disp = disp; v.irq = irq; v.ival = ival;
    v.rv = '0; v.rt = '0; v.rval = '0; v.rf = '0;
    v.chk = 1'b1; v.e_halt = eh; v.e_fault = ef; v.e_val = ev; v.e_tag = et;
    return v;
  endfunction

  function automatic vec_t ret(vec_t vin, int ch, logic [3:0] tag, logic [31:0] val, logic [2:0] f);
    vec_t v;
    v = vin;
    v.rv[ch] = 1'b1; v.rt[ch] = tag; v.rval[ch] = val; v.rf[ch] = f;
    return v;
  endfunction

  // Reset cycle with competing dispatch, interrupt and return activity that must be ignored.
  function automatic vec_t rst_vec();
    vec_t v;
    v = ret(op(1'b1, 8'h10, 1'b1, 1'b1, 32'h33, 1'b0, 3'd0, 32'h0, 4'd0), 0, 4'd15, 32'h77, 3'd4);
    v.rst = 1'b1;
    v.chk = 1'b0;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(vec_t v, string name);
    @(negedge clk);
    reset               = v.rst;
    instr_valid         = v.iv;
    instruction         = v.instr;
    dispatch            = v.disp;
    servicing_interrupt = v.irq;
    interrupt_value     = v.ival;
    ret_valid           = v.rv;
    ret_tag             = v.rt;
    ret_value           = v.rval;
    ret_fault           = v.rf;
    #1;
    if (v.chk) begin
      check({name, " halt"},  32'(halt),           32'(v.e_halt));
      check({name, " fault"}, 32'(fault),          32'(v.e_fault));
      check({name, " value"}, conveyor_value,      v.e_val);
      check({name, " tag"},   32'(dispatch_tag),   32'(v.e_tag));
    end
  endtask

  initial begin
    // Directed table: iv, instr, disp, irq, ival | halt, fault, value, tag
    vecs.push_back(op(0, 8'h00, 0, 0, 0, 0, 0, 32'h0, 15));                                   // 0 idle after reset
    vecs.push_back(op(1, 8'h13, 0, 0, 0, 0, 0, 32'h0, 15));                                   // 1 CVZ +3 on reset slot
    vecs.push_back(op(1, 8'h00, 1, 0, 0, 0, 0, 32'h0, 15));                                   // 2 dispatch -> slot 15
    vecs.push_back(ret(op(1, 8'h10, 0, 0, 0, 1, 0, 32'h0, 14), 0, 15, 32'hDEADBEEF, 0));      // 3 CVZ pending + return
    vecs.push_back(op(1, 8'h10, 0, 0, 0, 0, 0, 32'hDEADBEEF, 14));                            // 4 CVZ completes
    vecs.push_back(op(1, 8'h11, 0, 0, 0, 0, 0, 32'h0, 14));                                   // 5 CVZ +1 -> slot 0
    vecs.push_back(ret(op(1, 8'h10, 0, 0, 0, 0, 0, 32'hDEADBEEF, 14), 0, 15, 32'h1234, 3));   // 6 return to finished
    vecs.push_back(op(1, 8'h10, 0, 0, 0, 0, 0, 32'hDEADBEEF, 14));                            // 7 ignored return
    vecs.push_back(rst_vec());                                                                // 8
    vecs.push_back(op(0, 8'h0F, 0, 0, 0, 0, 0, 32'h0, 15));                                   // 9 reset overrode all
    vecs.push_back(op(1, 8'h00, 1, 0, 0, 0, 0, 32'h0, 15));                                   // 10 dispatch -> 15
    vecs.push_back(op(0, 8'h10, 0, 0, 0, 0, 0, 32'h0, 14));                                   // 11 CVZ without valid
    vecs.push_back(ret(ret(op(1, 8'h10, 0, 0, 0, 1, 0, 32'h0, 14), 0, 15, 32'h11, 0), 1, 15, 32'h22, 5)); // 12 dual return
    vecs.push_back(op(1, 8'h10, 0, 0, 0, 0, 0, 32'h11, 14));                                  // 13 channel 0 won
    vecs.push_back(op(1, 8'h00, 1, 0, 0, 0, 0, 32'h11, 14));                                  // 14 dispatch -> 14
    vecs.push_back(ret(op(1, 8'h10, 0, 0, 0, 1, 0, 32'h0, 13), 1, 14, 32'hABCD, 2));          // 15 faulting return
    vecs.push_back(op(1, 8'h10, 0, 0, 0, 0, 2, 32'hABCD, 13));                                // 16 fault reported
    vecs.push_back(op(1, 8'h11, 0, 0, 0, 0, 0, 32'h11, 13));                                  // 17
    vecs.push_back(rst_vec());                                                                // 18
    vecs.push_back(op(1, 8'h10, 1, 1, 32'h5A, 0, 0, 32'h0, 15));                              // 19 interrupt wins
    vecs.push_back(op(1, 8'h10, 0, 0, 0, 0, 0, 32'h5A, 14));                                  // 20
    vecs.push_back(op(1, 8'h00, 1, 0, 0, 0, 0, 32'h5A, 14));                                  // 21 dispatch -> 14
    vecs.push_back(op(1, 8'h10, 0, 1, 32'h77, 0, 0, 32'h0, 13));                              // 22 irq masks halt
    vecs.push_back(op(1, 8'h10, 0, 0, 0, 0, 0, 32'h77, 12));                                  // 23
    vecs.push_back(op(1, 8'h11, 0, 0, 0, 1, 0, 32'h0, 12));                                   // 24 slot 14 pending
    vecs.push_back(op(1, 8'h12, 0, 0, 0, 0, 0, 32'h5A, 12));                                  // 25

    apply(rst_vec(), "init0");
    apply(rst_vec(), "init1");
    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // Fill the whole ring, then hit the wrap-around and dispatch-vs-return collision.
    apply(rst_vec(), "wrap_rst");
    for (int i = 0; i < 16; i++) begin
      apply(op(1, 8'h00, 1, 0, 0, 0, 0, 32'h0, 4'(15 - i)), $sformatf("fill%0d", i));
    end
`ifdef CONVEYOR_PENDING_LIMIT_EN
    apply(ret(op(1, 8'h00, 1, 0, 0, 1, 0, 32'h0, 15), 0, 15, 32'h99, 0), "full_dispatch");
    apply(op(1, 8'h00, 1, 0, 0, 0, 0, 32'h0, 15), "after_return");
`else
    apply(ret(op(1, 8'h00, 1, 0, 0, 0, 0, 32'h0, 15), 0, 15, 32'h99, 0), "overwrite");
`endif
    apply(ret(op(1, 8'h10, 0, 0, 0, 1, 0, 32'h0, 14), 0, 0, 32'hC0DE, 1), "realloc_pending");
    apply(op(1, 8'h11, 0, 0, 0, 0, 1, 32'hC0DE, 14), "wrap_index");

    apply(op(0, 8'h00, 0, 0, 0, 0, 0, 32'h0, 14), "final_idle");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
